// File: rtl/uart_rx_fifo.sv
// ============================================================================
// uart_rx_fifo : 8N1 UART receiver feeding a show-ahead byte FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 4166,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ser_rx,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   rx_level,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr,
  output logic                          rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH    = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            sync1, rx_s;
  logic            push, fe_set;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr, rd_ptr;
  logic            full, pop, wr_en, ov_set;

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= ser_rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    fe_set  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_BIT) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == FULL_BIT) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s;
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (cnt_q == FULL_BIT) begin
          cnt_d = '0;
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_set  = 1'b1;
            state_d = BRK;
          end
        end
      end
      BRK: begin
        // A held-low line must produce only one framing error
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rx_busy  = (state_q != IDLE);
  assign rx_level = wr_ptr - rd_ptr;
  assign rx_valid = (rx_level != '0);
  assign full     = (rx_level == DEPTH);
  assign pop      = rx_valid & rx_ready;
  assign wr_en    = push & (~full | pop);
  assign ov_set   = push & full & ~pop;
  assign rx_data  = rx_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW + 1)'(1);
      // Set events take priority over a simultaneous clear
      if (fe_set)       frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
      if (ov_set)       overrun   <= 1'b1;
      else if (err_clr) overrun   <= 1'b0;
    end
  end

endmodule

`default_nettype wire
